// File: rtl/reg_file_if.sv
// Controller-side bus of the register file: strobes, address, data,
// registered read result and the four live exports of registers 0-3.
interface reg_file_if #(
   parameter int W = 8,
   parameter int A = 4
);
   logic         write_en;
   logic         read_en;
   logic [A-1:0] address;
   logic [W-1:0] write_data;
   logic [W-1:0] read_data;
   logic         read_valid;
   logic [W-1:0] reg0;
   logic [W-1:0] reg1;
   logic [W-1:0] reg2;
   logic [W-1:0] reg3;

   modport master (
      output write_en, read_en, address, write_data,
      input  read_data, read_valid, reg0, reg1, reg2, reg3
   );

   modport slave (
      input  write_en, read_en, address, write_data,
      output read_data, read_valid, reg0, reg1, reg2, reg3
   );
endinterface

// File: rtl/reg_file.sv
// Register file: W-bit x DEPTH storage, registered reads, regs 0-3 exported.
// Ports: clk, rst (async active-low), bus (reg_file_if.slave).
module reg_file #(
   parameter int W     = 8,
   parameter int A     = 4,
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   reg_file_if.slave  bus
);
   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rdata;
   logic         r_rvalid;
   logic         w_in_range;

   // Range check only exists when the address space exceeds DEPTH.
   generate
      if (DEPTH == (1 << A)) begin : g_full
         assign w_in_range = 1'b1;
      end else begin : g_part
         assign w_in_range = (bus.address < A'(DEPTH));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_mem[2] <= W'(8'h81);
         r_mem[3] <= W'(8'h20);
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else if (bus.write_en) begin
         // A write always wins over a simultaneous read.
         if (w_in_range) begin
            r_mem[bus.address] <= bus.write_data;
         end
         r_rvalid <= 1'b0;
      end else if (bus.read_en) begin
         r_rdata  <= w_in_range ? r_mem[bus.address] : '0;
         r_rvalid <= 1'b1;
      end
   end

   assign bus.read_data  = r_rdata;
   assign bus.read_valid = r_rvalid;
   assign bus.reg0       = r_mem[0];
   assign bus.reg1       = r_mem[1];
   assign bus.reg2       = r_mem[2];
   assign bus.reg3       = r_mem[3];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_reg_file;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   logic [7:0] m_mem [16];
   logic [7:0] m_rdata;
   logic       m_rvalid;

   reg_file_if #(.W(8), .A(4)) bus ();

   reg_file #(.W(8), .A(4), .DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_mem[2] = 8'h81;
      m_mem[3] = 8'h20;
      m_rdata  = 8'h00;
      m_rvalid = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".rdata"}, 32'(bus.read_data), 32'(m_rdata));
      chk({tag, ".rvalid"}, 32'(bus.read_valid), 32'(m_rvalid));
      chk({tag, ".reg0"}, 32'(bus.reg0), 32'(m_mem[0]));
      chk({tag, ".reg1"}, 32'(bus.reg1), 32'(m_mem[1]));
      chk({tag, ".reg2"}, 32'(bus.reg2), 32'(m_mem[2]));
      chk({tag, ".reg3"}, 32'(bus.reg3), 32'(m_mem[3]));
   endtask

   // One clock cycle of traffic; the model applies the spec rules.
   task automatic step(input logic we, input logic re,
                       input logic [3:0] ad, input logic [7:0] wd);
      bus.write_en   = we;
      bus.read_en    = re;
      bus.address    = ad;
      bus.write_data = wd;
      @(posedge clk);
      if (we) begin
         m_mem[ad] = wd;
         m_rvalid  = 1'b0;
      end else if (re) begin
         m_rdata  = m_mem[ad];
         m_rvalid = 1'b1;
      end
      #1;
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      bus.write_en   = 1'b0;
      bus.read_en    = 1'b0;
      bus.address    = '0;
      bus.write_data = '0;
      rst = 1'b0;
      model_reset();
      #23;
      check_all("rst");
      rst = 1'b1;
      #10;
      check_all("post_rst");

      step(1'b0, 1'b1, 4'd5, 8'h00);
      chk("rd5", 32'(bus.read_data), 32'h00);
      check_all("rd5");

      step(1'b1, 1'b0, 4'd7, 8'h3C);
      step(1'b0, 1'b1, 4'd7, 8'h00);
      chk("wr_rd7", 32'(bus.read_data), 32'h3C);
      chk("wr_rd7_v", 32'(bus.read_valid), 32'h1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 4'd0, 8'h00);
         chk("hold_v", 32'(bus.read_valid), 32'h1);
      end
      step(1'b1, 1'b0, 4'd9, 8'hA5);
      chk("wr_drop_v", 32'(bus.read_valid), 32'h0);
      check_all("wr9");

      step(1'b1, 1'b0, 4'd0, 8'h12);
      chk("reg0", 32'(bus.reg0), 32'h12);
      step(1'b1, 1'b0, 4'd1, 8'h34);
      chk("reg1", 32'(bus.reg1), 32'h34);
      chk("reg2_keep", 32'(bus.reg2), 32'h81);
      chk("reg3_keep", 32'(bus.reg3), 32'h20);

      step(1'b0, 1'b1, 4'd3, 8'h00);
      step(1'b1, 1'b1, 4'd2, 8'h55);
      chk("coll_reg2", 32'(bus.reg2), 32'h55);
      chk("coll_v", 32'(bus.read_valid), 32'h0);
      chk("coll_rd", 32'(bus.read_data), 32'h20);

      step(1'b0, 1'b1, 4'd0, 8'h00);
      chk("b2b0", 32'(bus.read_data), 32'h12);
      chk("b2b0_v", 32'(bus.read_valid), 32'h1);
      step(1'b0, 1'b1, 4'd1, 8'h00);
      chk("b2b1", 32'(bus.read_data), 32'h34);
      chk("b2b1_v", 32'(bus.read_valid), 32'h1);

      #3;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #1;
      rst = 1'b1;

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
              4'($urandom_range(0, 15)), 8'($urandom));
         check_all("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
